display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1: 1 = blank leading zeros, 0 = show all four digits.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port value, input, 14 bits: unsigned binary count to display, for example tickets remaining.
REQ-006 The block SHALL have port load, input, 1 bit: one-cycle strobe that samples value.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port an, output, 4 bits: active-low digit enables; bit 0 is the units digit.
REQ-009 The block SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and CONV; reset state is IDLE.
REQ-011 In IDLE, load=1 SHALL capture value into the shift register, clear the BCD accumulator, set busy=1 and move to CONV on the same edge.
REQ-012 CONV SHALL run exactly 14 cycles of shift-and-add-3: before each left shift, add 3 to any BCD nibble that is ≥5.
REQ-013 On the 14th CONV cycle the result SHALL be written to the 16-bit display register, then busy=0 and the FSM returns to IDLE.
REQ-014 The display register SHALL update 15 cycles after the edge that samples load.
REQ-015 Captured value > 9999 SHALL saturate to 9999 before conversion.
REQ-016 load asserted while busy=1 SHALL be ignored, with no queuing; load in the cycle busy falls SHALL be accepted.
REQ-017 The display register SHALL keep its old contents during CONV, so no partial result is ever shown.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the 2-bit scan index advances 0→1→2→3→0.
REQ-019 an and seg SHALL be registered, reflecting the scan index one cycle later; exactly one an bit is low at any time outside reset.
REQ-020 Leading-zero blanking (BLANK_LZ=1): a digit above the most significant nonzero digit SHALL decode as code 4'hF, giving seg=7'b1111111.
REQ-021 The units digit SHALL never be blanked; a display value of 0 shows "   0".
REQ-022 Segment encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, other=1111111.

Reset
REQ-023 rst=1 SHALL immediately force the following, regardless of clk: FSM=IDLE, busy=0, display register=0, refresh counter=0, scan index=0, an=4'b1111, seg=7'b1111111.
REQ-024 rst asserted mid-CONV SHALL abort the conversion; the display register is not updated.
REQ-025 On the first clk edge after rst falls, an SHALL become 4'b1110 and seg SHALL become 7'b1000000.

Structure
REQ-026 A shared package SHALL hold: state encoding (IDLE=0, CONV=1), constants CONV_CYCLES=14, VALUE_MAX=9999, BLANK_CODE=4'hF, AN_OFF=4'b1111.
REQ-027 Segment decoding SHALL use one instance of the existing sub-module bcd_to_7seg, driven by the muxed digit or BLANK_CODE.
REQ-028 The converter, refresh counter and scan logic SHALL remain in display_scan_ctrl.

Verification (REFRESH_DIV=4)
REQ-029 Reset release: rst 1→0, no load → an cycles 1110,1101,1011,0111 every 4 clocks; seg=1000000 on units, 1111111 on the others.
REQ-030 Load 1234: busy high for exactly 14 cycles; from load+15, digits scan 4,3,2,1 → 0011001, 0110000, 0100100, 1111001.
REQ-031 Load 16383 → displays 9999; load 7 → "   7", only the units digit non-blank.
REQ-032 Load 50, then load 999 three cycles later → 999 ignored; display shows 50; busy pulse is single and 14 cycles long.
REQ-033 Load 8888, rst asserted at CONV cycle 6 → immediate AN_OFF; busy=0; after release the display shows 0.
REQ-034 Back-to-back: load 1 on the cycle busy falls after load 2 → displays 2, then 1 exactly 15 cycles later.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the display scan controller.
package display_scan_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int         CONV_CYCLES = 14;
  localparam int         VALUE_MAX   = 9999;
  localparam logic [3:0] BLANK_CODE  = 4'hF;
  localparam logic [3:0] AN_OFF      = 4'b1111;
  localparam logic [6:0] SEG_OFF     = 7'b1111111;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 (including the blank code) turn every segment off.
module bcd_to_7seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup, no state.
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver. A binary count is converted
// to BCD by a serial shift-and-add-3 engine, then scanned out one digit at
// a time with optional leading-zero blanking.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for load; display register holds the last result
// CONV  | 14 shift-and-add-3 steps; display register left untouched
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int              RW           = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]   REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [3:0]      CONV_LOAD    = 4'(CONV_CYCLES);
  localparam logic [13:0]     SAT_VALUE    = 14'(VALUE_MAX);

  state_t        state, state_nxt;
  logic          capture, last_step;
  logic [13:0]   shreg;
  logic [15:0]   bcd;
  logic [3:0]    conv_cnt;
  logic [15:0]   disp;
  logic [29:0]   shifted;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    seg_digit;
  logic [6:0]    seg_dec;

  assign busy = (state == CONV);

  // One conversion step: correct the BCD nibbles, then shift {bcd, shreg} left.
  always_comb begin
    shifted = {bcd_adjust(bcd), shreg} << 1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: accept load only in IDLE; leave CONV after the last step.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (conv_cnt == 4'd1) begin
          last_step = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath; the display register only changes on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bcd      <= '0;
      conv_cnt <= '0;
      disp     <= '0;
    end else if (capture) begin
      shreg    <= (value > SAT_VALUE) ? SAT_VALUE : value;
      bcd      <= '0;
      conv_cnt <= CONV_LOAD;
    end else if (state == CONV) begin
      bcd      <= shifted[29:14];
      shreg    <= shifted[13:0];
      conv_cnt <= conv_cnt - 4'd1;
      if (last_step) disp <= shifted[29:14];
    end
  end

  // Refresh timer; each wrap moves the scan to the next digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Pick the scanned digit and blank it if everything above it is zero.
  always_comb begin
    digit = disp[{scan_idx, 2'b00} +: 4];
    blank = 1'b0;
    if (BLANK_LZ) begin
      case (scan_idx)
        2'd3:    blank = (disp[15:12] == 4'd0);
        2'd2:    blank = (disp[15:8]  == 8'd0);
        2'd1:    blank = (disp[15:4]  == 12'd0);
        default: blank = 1'b0;
      endcase
    end
    seg_digit = blank ? BLANK_CODE : digit;
  end

  bcd_to_7seg u_seg (
    .digit (seg_digit),
    .seg   (seg_dec)
  );

  // Registered drivers so anode and segment change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(4'b0001 << scan_idx);
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short refresh period.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_errors = 0;

  display_scan_ctrl #(
    .REFRESH_DIV (4),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .an    (an),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Expected segment pattern of digit position idx for decimal value d.
  function automatic int exp_seg(input int d, input int idx);
    int p;
    int dig;
    if (idx < 0) return 'h7F;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && d < p) return 'h7F;
    dig = (d / p) % 10;
    case (dig)
      0: return 'b1000000;
      1: return 'b1111001;
      2: return 'b0100100;
      3: return 'b0110000;
      4: return 'b0011001;
      5: return 'b0010010;
      6: return 'b0000010;
      7: return 'b1111000;
      8: return 'b0000000;
      9: return 'b0010000;
      default: return 'h7F;
    endcase
  endfunction

  task automatic pulse_load(input int v);
    value = 14'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Load v, optionally poke a second load mid-conversion (dup_at) or chain
  // another load on the cycle busy drops; checks busy length and the exact
  // cycle the displayed digit switches over.
  task automatic conv(input int v, input int old_d, input int new_d,
                      input int dup_at, input bit chain, input int chain_v);
    int hi;
    int idx;
    int last_k;
    last_k = chain ? 30 : 15;
    pulse_load(v);
    hi = busy ? 1 : 0;
    for (int k = 1; k <= last_k; k++) begin
      if (k == dup_at) begin
        value = 14'd999;
        load  = 1'b1;
      end
      if (chain && k == 15) begin
        value = 14'(chain_v);
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
      if (busy) hi++;
      idx = an_idx(an);
      if (k == 14) chk("pre_update", int'(seg), exp_seg(old_d, idx));
      if (k == 15) chk("post_update", int'(seg), exp_seg(new_d, idx));
      if (chain && k == 29) chk("chain_pre", int'(seg), exp_seg(new_d, idx));
      if (chain && k == 30) chk("chain_post", int'(seg), exp_seg(chain_v, idx));
    end
    chk("busy_len", hi, chain ? 28 : 14);
  endtask

  // Watch a full scan round and compare every digit position.
  task automatic scan_check(input int d);
    int obs[4];
    int idx;
    for (int i = 0; i < 4; i++) obs[i] = -1;
    for (int k = 0; k < 16; k++) begin
      tick();
      idx = an_idx(an);
      chk("an_onehot", int'(idx >= 0), 1);
      if (idx >= 0) obs[idx] = int'(seg);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("digit%0d_of_%0d", i, d), obs[i], exp_seg(d, i));
  endtask

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    value = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_an", int'(an), 'b1111);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;

    // Scan pattern after reset release: each anode holds for 4 clocks.
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("scan_an_%0d", k), int'(an), int'(~(4'b0001 << ((k - 1) / 4))) & 'hF);
      chk($sformatf("scan_seg_%0d", k), int'(seg), (k <= 4) ? 'b1000000 : 'h7F);
    end

    conv(1234, 0, 1234, 0, 1'b0, 0);
    scan_check(1234);
    chk("d1234_u", exp_seg(1234, 0), 'b0011001);

    conv(16383, 1234, 9999, 0, 1'b0, 0);
    scan_check(9999);

    conv(7, 9999, 7, 0, 1'b0, 0);
    scan_check(7);

    conv(50, 7, 50, 3, 1'b0, 0);
    scan_check(50);

    conv(2, 50, 2, 0, 1'b1, 1);
    scan_check(1);

    // Reset in the middle of a conversion.
    pulse_load(8888);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_an", int'(an), 'b1111);
    chk("abort_seg", int'(seg), 'h7F);
    chk("abort_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rel_an", int'(an), 'b1110);
    chk("rel_seg", int'(seg), 'b1000000);
    scan_check(0);
    chk("post_abort_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
